// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_skew_feeder_pkg: constants and types shared by the feeder and the processor array
// Contents: GF element widths, op code constants, gauss op type and the feeder FSM state type.
package systolic_skew_feeder_pkg;
    localparam int GF_BIT_4 = 4;
    localparam int GF_BIT_8 = 8;
    localparam int OP_CODE_W = 4;
    localparam logic [OP_CODE_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_CODE_W-1:0] OP_MUL   = 4'd1;
    localparam logic [OP_CODE_W-1:0] OP_ADD   = 4'd2;
    localparam logic [OP_CODE_W-1:0] OP_GAUSS = 4'd3;
    localparam logic [OP_CODE_W-1:0] OP_LOAD  = 4'd4;
    typedef enum logic [1:0] {GAUSS_NONE, GAUSS_PIVOT, GAUSS_ELIM, GAUSS_SWAP} gauss_op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM} state_t;
endpackage

// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: matrix input handshake and skewed lane output bundle
// master: source of matrix words, sink of lane streams; slave: the feeder.
interface systolic_skew_feeder_if #(
    parameter int GF_BIT = 4,
    parameter int OP_CODE_LEN = 4,
    parameter int N = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N*GF_BIT-1:0]      in_data;
    logic [OP_CODE_LEN-1:0]   in_op;
    logic [1:0]               in_gauss_op;
    logic [N*GF_BIT-1:0]      lane_data;
    logic [N-1:0]             lane_start;
    logic [N-1:0]             lane_finish;
    logic [OP_CODE_LEN-1:0]   op_out;
    logic [1:0]               gauss_op_out;
    logic                     busy;
    logic                     done;
    modport master (
        output in_valid, in_data, in_op, in_gauss_op,
        input  in_ready, lane_data, lane_start, lane_finish, op_out, gauss_op_out, busy, done
    );
    modport slave (
        input  in_valid, in_data, in_op, in_gauss_op,
        output in_ready, lane_data, lane_start, lane_finish, op_out, gauss_op_out, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder_word_buf.sv
// feeder_word_buf: ROWS x N*GF_BIT matrix store with one write port and N element read ports
// Ports: clk; we/waddr/wdata write a whole word; raddr holds one word index per lane,
// rdata returns element i of word raddr[i] for each lane i (0 for out-of-range indices).
module feeder_word_buf #(
    parameter int GF_BIT = 4,
    parameter int N = 8,
    parameter int ROWS = 16,
    localparam int KW = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [KW-1:0]       waddr,
    input  logic [N*GF_BIT-1:0] wdata,
    input  logic [N*KW-1:0]     raddr,
    output logic [N*GF_BIT-1:0] rdata
);
    logic [N*GF_BIT-1:0] mem [ROWS];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N; i++)
            rdata[i*GF_BIT +: GF_BIT] = int'(raddr[i*KW +: KW]) < ROWS ? mem[raddr[i*KW +: KW]][i*GF_BIT +: GF_BIT] : '0;
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers one matrix and streams it diagonally skewed into N processor lanes
// Ports: clk, rst_n (async, active-low); bus (slave) carries the word handshake in and the
// per-lane data/start/finish, op/gauss op, busy and done out. All outputs except in_ready are registered.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int GF_BIT = GF_BIT_4,
    parameter int OP_CODE_LEN = OP_CODE_W,
    parameter int N = 8,
    parameter int ROWS = 16
) (
    input logic clk,
    input logic rst_n,
    systolic_skew_feeder_if.slave bus
);
    localparam int KW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS + N);
    localparam int LAST = ROWS + N - 2;
    state_t                 state;
    logic [KW-1:0]          k;
    logic [CW-1:0]          c;
    logic [CW-1:0]          cn;
    logic [OP_CODE_LEN-1:0] op_q;
    gauss_op_t              gauss_q;
    logic [N*KW-1:0]        raddr;
    logic [N*GF_BIT-1:0]    rdata;
    logic [N*GF_BIT-1:0]    lane_next;
    logic [N-1:0]           st_next;
    logic [N-1:0]           fin_next;
    logic                   accept;
    logic                   last_word;
    logic                   last_cycle;
    logic                   out_en;
    assign bus.in_ready = state != ST_STREAM;
    assign accept = bus.in_valid && bus.in_ready;
    assign last_word = state == ST_LOAD && k == KW'(ROWS - 1);
    assign last_cycle = c == CW'(LAST);
    // the output registers always hold the values of the cycle being entered, so the
    // decode works on the next stream index; the last accept loads cycle 0
    assign cn = state == ST_STREAM ? c + 1'b1 : '0;
    assign out_en = (accept && last_word) || (state == ST_STREAM && !last_cycle);
    feeder_word_buf #(.GF_BIT(GF_BIT), .N(N), .ROWS(ROWS)) u_buf (
        .clk(clk),
        .we(accept),
        .waddr(k),
        .wdata(bus.in_data),
        .raddr(raddr),
        .rdata(rdata)
    );
    // lane i is the stream delayed by i cycles: it shows word cn-i inside its ROWS-long window
    always_comb begin
        lane_next = '0;
        st_next = '0;
        fin_next = '0;
        raddr = '0;
        for (int i = 0; i < N; i++) begin
            raddr[i*KW +: KW] = KW'(int'(cn) - i);
            lane_next[i*GF_BIT +: GF_BIT] = int'(cn) >= i && int'(cn) < i + ROWS ? rdata[i*GF_BIT +: GF_BIT] : '0;
            st_next[i] = int'(cn) == i;
            fin_next[i] = int'(cn) == i + ROWS - 1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            k <= '0;
            c <= '0;
            op_q <= '0;
            gauss_q <= GAUSS_NONE;
        end else begin
            unique case (state)
                ST_IDLE: if (accept) begin
                    state <= ST_LOAD;
                    k <= KW'(1);
                    op_q <= bus.in_op;
                    gauss_q <= gauss_op_t'(bus.in_gauss_op);
                end
                ST_LOAD: if (accept) begin
                    state <= last_word ? ST_STREAM : ST_LOAD;
                    k <= last_word ? '0 : k + 1'b1;
                    c <= '0;
                end
                ST_STREAM: begin
                    state <= last_cycle ? ST_IDLE : ST_STREAM;
                    c <= last_cycle ? '0 : cn;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.lane_data <= '0;
            bus.lane_start <= '0;
            bus.lane_finish <= '0;
            bus.op_out <= '0;
            bus.gauss_op_out <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.lane_data <= out_en ? lane_next : '0;
            bus.lane_start <= out_en ? st_next : '0;
            bus.lane_finish <= out_en ? fin_next : '0;
            bus.op_out <= out_en ? op_q : '0;
            bus.gauss_op_out <= out_en ? gauss_q : GAUSS_NONE;
            bus.busy <= (state == ST_IDLE && accept) || state == ST_LOAD || (state == ST_STREAM && !last_cycle);
            bus.done <= state == ST_STREAM && last_cycle;
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: randomized and directed checks of the skew feeder against a matrix-level model
module tb_systolic_skew_feeder;
    localparam int GB = 4;
    localparam int OL = 4;
    localparam int N = 4;
    localparam int ROWS = 3;
    localparam int LAST = ROWS + N - 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [N*GB-1:0] m_words [ROWS];
    int m_cnt;
    int m_t;
    logic [OL-1:0] m_op;
    logic [1:0] m_g;
    logic m_done;
    systolic_skew_feeder_if #(.GF_BIT(GB), .OP_CODE_LEN(OL), .N(N)) a ();
    systolic_skew_feeder_if #(.GF_BIT(GB), .OP_CODE_LEN(OL), .N(1)) b ();
    systolic_skew_feeder #(.GF_BIT(GB), .OP_CODE_LEN(OL), .N(N), .ROWS(ROWS)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a)
    );
    systolic_skew_feeder #(.GF_BIT(GB), .OP_CODE_LEN(OL), .N(1), .ROWS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [N*GB-1:0] mk(input int w);
        logic [N*GB-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*GB +: GB] = 4'((w % 4) * 4 + i);
        return r;
    endfunction
    task automatic model_reset();
        m_cnt = 0;
        m_t = -1;
        m_op = '0;
        m_g = '0;
        m_done = 1'b0;
    endtask
    // m_t is the stream cycle on display (-1 when not streaming); lane i shows word m_t-i
    task automatic check_a();
        logic [N*GB-1:0] ed;
        logic [N-1:0] es;
        logic [N-1:0] ef;
        ed = '0;
        es = '0;
        ef = '0;
        for (int i = 0; i < N; i++)
            if (m_t >= i && m_t < i + ROWS) begin
                ed[i*GB +: GB] = m_words[m_t-i][i*GB +: GB];
                es[i] = m_t == i;
                ef[i] = m_t == i + ROWS - 1;
            end
        chk("lane_data", 32'(a.lane_data), 32'(ed));
        chk("lane_start", 32'(a.lane_start), 32'(es));
        chk("lane_finish", 32'(a.lane_finish), 32'(ef));
        chk("in_ready", 32'(a.in_ready), 32'(m_t < 0));
        chk("busy", 32'(a.busy), 32'(m_cnt > 0 || m_t >= 0));
        chk("done", 32'(a.done), 32'(m_done));
        chk("op_out", 32'(a.op_out), m_t >= 0 ? 32'(m_op) : 32'(0));
        chk("gauss_op_out", 32'(a.gauss_op_out), m_t >= 0 ? 32'(m_g) : 32'(0));
    endtask
    task automatic step(input logic v, input logic [N*GB-1:0] d, input logic [OL-1:0] op, input logic [1:0] g);
        logic nd;
        a.in_valid = v;
        a.in_data = d;
        a.in_op = op;
        a.in_gauss_op = g;
        @(posedge clk);
        nd = m_t == LAST;
        if (m_t >= 0) m_t = m_t == LAST ? -1 : m_t + 1;
        else if (v) begin
            if (m_cnt == 0) begin
                m_op = op;
                m_g = g;
            end
            m_words[m_cnt] = d;
            m_cnt++;
            if (m_cnt == ROWS) begin
                m_cnt = 0;
                m_t = 0;
            end
        end
        m_done = nd;
        @(negedge clk);
        check_a();
    endtask
    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, '0, '0, '0);
    endtask
    initial begin
        logic [N*GB-1:0] rd;
        model_reset();
        a.in_valid = 1'b0;
        a.in_data = '0;
        a.in_op = '0;
        a.in_gauss_op = '0;
        b.in_valid = 1'b0;
        b.in_data = '0;
        b.in_op = '0;
        b.in_gauss_op = '0;
        #1;
        check_a();
        chk("b_reset_ready", 32'(b.in_ready), 32'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int w = 0; w < ROWS; w++) step(1'b1, mk(w), 4'd4, 2'd3);
        idle(8);
        for (int j = 0; j < 5; j++) step(j % 2 == 0, mk(j / 2), 4'd4, 2'd3);
        idle(8);
        for (int w = 0; w < ROWS; w++) step(1'b1, mk(w), 4'd6, 2'd1);
        for (int j = 0; j <= LAST; j++) step(1'b1, 16'hFFFF, 4'd6, 2'd1);
        step(1'b1, 16'hFFFF, 4'd9, 2'd2);
        step(1'b1, mk(1), 4'd9, 2'd2);
        step(1'b1, mk(2), 4'd9, 2'd2);
        idle(8);
        for (int w = 0; w < ROWS; w++) step(1'b1, mk(w + 1), 4'd7, 2'd2);
        idle(2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_a();
        @(negedge clk);
        check_a();
        rst_n = 1'b1;
        for (int w = 0; w < ROWS; w++) step(1'b1, 16'($urandom), 4'd2, 2'd1);
        idle(8);
        step(1'b1, mk(0), 4'h3, 2'd1);
        step(1'b1, mk(1), 4'hA, 2'd2);
        step(1'b1, mk(2), 4'hF, 2'd0);
        idle(8);
        for (int j = 0; j < 300; j++) begin
            rd = 16'($urandom);
            step(1'($urandom_range(0, 1)), rd, 4'($urandom), 2'($urandom));
        end
        idle(8);
        b.in_valid = 1'b1;
        b.in_data = 4'h0;
        b.in_op = 4'd5;
        b.in_gauss_op = 2'd1;
        @(posedge clk);
        @(negedge clk);
        chk("b_busy_load", 32'(b.busy), 32'(1));
        chk("b_ready_load", 32'(b.in_ready), 32'(1));
        b.in_data = 4'h4;
        b.in_op = 4'd8;
        @(posedge clk);
        @(negedge clk);
        b.in_valid = 1'b0;
        chk("b_data0", 32'(b.lane_data), 32'(0));
        chk("b_start0", 32'(b.lane_start), 32'(1));
        chk("b_finish0", 32'(b.lane_finish), 32'(0));
        chk("b_op", 32'(b.op_out), 32'(5));
        chk("b_gauss", 32'(b.gauss_op_out), 32'(1));
        chk("b_ready_stream", 32'(b.in_ready), 32'(0));
        @(negedge clk);
        chk("b_data1", 32'(b.lane_data), 32'(4));
        chk("b_start1", 32'(b.lane_start), 32'(0));
        chk("b_finish1", 32'(b.lane_finish), 32'(1));
        chk("b_done_early", 32'(b.done), 32'(0));
        @(negedge clk);
        chk("b_done", 32'(b.done), 32'(1));
        chk("b_busy_done", 32'(b.busy), 32'(0));
        chk("b_finish_off", 32'(b.lane_finish), 32'(0));
        chk("b_op_off", 32'(b.op_out), 32'(0));
        @(negedge clk);
        chk("b_done_pulse", 32'(b.done), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for a row of chained `processor_ABCD` cells. It accepts one matrix of `ROWS` packed words over a valid/ready handshake and buffers it completely. It then streams the matrix into `N` processor lanes with the systolic diagonal skew: lane `i` is delayed `i` cycles. Per-lane start/finish flags frame each lane's stream, and the latched op code and gauss op are presented to the first processor column for the whole burst.

## Interface
Parameters:
- `GF_BIT`, 4 — field element width; 4 or 8.
- `OP_CODE_LEN`, 4 — op code width.
- `N`, 8 — number of lanes (elements per input word); must be ≥1.
- `ROWS`, 16 — words per matrix; must be ≥2.

Ports:
- `clk`  in  1  — the single clock.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `in_valid`  in  1  — input word valid.
- `in_ready`  out  1  — feeder can accept a word.
- `in_data`  in  N*GF_BIT  — element `i` at bits `[i*GF_BIT +: GF_BIT]`.
- `in_op`  in  OP_CODE_LEN  — op code; sampled with word 0.
- `in_gauss_op`  in  2  — gauss op; sampled with word 0.
- `lane_data`  out  N*GF_BIT  — per-lane element, same packing as `in_data`.
- `lane_start`  out  N  — start flag per lane.
- `lane_finish`  out  N  — finish flag per lane.
- `op_out`  out  OP_CODE_LEN  — latched op during the burst, else 0.
- `gauss_op_out`  out  2  — latched gauss op during the burst, else 0.
- `busy`  out  1  — high in LOAD and STREAM.
- `done`  out  1  — one-cycle pulse after the burst ends.

## Operation
- **FSM states:** IDLE, LOAD, STREAM.
- **IDLE:**
  - `in_ready` = 1.
  - A handshake (`in_valid & in_ready`) stores word 0, latches `in_op` and `in_gauss_op`, sets the word counter `k` = 1 and moves to LOAD.
- **LOAD:**
  - `in_ready` = 1; each handshake stores word `k` and increments `k`.
  - No handshake means no change.
  - The handshake that stores word `ROWS-1` moves to STREAM with stream counter `c` = 0.
- **STREAM:**
  - `in_ready` = 0.
  - Runs `ROWS+N-1` output cycles, indexed `c` = 0..`ROWS+N-2`.
- **Lane `i`, output cycle `c`:**
  - Active when `i ≤ c < i+ROWS`; then `lane_data[i]` = `word[c-i][i]`, otherwise 0.
  - `lane_start[i]` = (`c == i`).
  - `lane_finish[i]` = (`c == i+ROWS-1`).
- **Op outputs:** `op_out` and `gauss_op_out` equal the latched values in every STREAM output cycle.
- **End of burst:** after output cycle `ROWS+N-2`:
  - All lane outputs, `op_out` and `gauss_op_out` return to 0.
  - `done` = 1 for one cycle.
  - The FSM returns to IDLE.
- **No stall:** the output side has no backpressure; a burst never pauses once STREAM begins.
- **Counter widths:** `k` is `$clog2(ROWS)` bits; `c` is `$clog2(ROWS+N)` bits. Neither counter wraps within a burst.

## Timing
- **Reset values:** all outputs registered, reset to 0 except `in_ready`. `in_ready` is decoded from state: 1 in IDLE/LOAD, 0 in STREAM, and therefore 1 while `rst_n` is low.
- **Load rate:** full throughput, one word per cycle when `in_valid` is held high.
- **Load latency:** a matrix with no input gaps loads in `ROWS` cycles.
- **Output latency:**
  - The edge that accepts word `ROWS-1` also loads the output registers with cycle `c`=0 values.
  - So `lane_start[0]` and `word0[0]` are visible in the cycle after the last accept.
  - `lane_start[i]` appears `i` cycles later.
- **Burst end:**
  - `lane_finish[N-1]` is visible `ROWS+N-1` cycles after the last accept edge.
  - `done` is high in the following cycle, with `busy` already 0 in that cycle.
- **Next matrix:** a new matrix may be accepted in the same cycle that `done` is high (IDLE, `in_ready` = 1).
- **`in_valid` in STREAM:** ignored; no storage occurs.
- **Reset mid-operation:** asserting `rst_n` low in any state clears outputs and counters asynchronously, returns to IDLE and discards the partial matrix. No `done` is issued.
- **Degenerate width N=1:** lane 0 only. The burst is `ROWS` cycles, with start at `c`=0 and finish at `c`=`ROWS-1`.

## Structure
- **Shared package:**
  - GF width constants.
  - Op code constants, shared with the processor array.
  - A `gauss_op` typedef.
  - The FSM state enum.
- **Sub-module `feeder_word_buf`:**
  - `ROWS` × `N*GF_BIT` register file with a write port and `N` independent element read ports.
  - Lane `i` reads element `i` of word `c-i`.
- **Top level:** FSM, counters, skew/window decode and output registers.

## Test plan
All scenarios use `GF_BIT`=4, `N`=4, `ROWS`=3, word `w` element `i` = `{w[1:0], i[1:0]}`.

1. **Basic burst:** load 3 words back-to-back, op=4, gauss=3.
   - Lane 0 shows 0x0,0x4,0x8 from cycle 1 after the last accept.
   - Lane 3 shows 0x3,0x7,0xB from cycle 4.
   - Start/finish land on each lane's first/last element.
   - `done` comes at cycle 7.
2. **Gapped load:** `in_valid` toggles 1,0,1,0,1.
   - Words are stored only on handshakes.
   - Outputs are identical to scenario 1, and the burst starts after the 5th cycle.
3. **Ignored input during STREAM:** hold `in_valid`=1 with data 0xFFFF throughout STREAM.
   - `in_ready`=0 and the stream is unaffected.
   - The next matrix is accepted in the `done` cycle.
4. **Reset mid-burst:** pull `rst_n` low at `c`=2.
   - All outputs are 0 immediately and no `done` is issued.
   - After release, `in_ready`=1 and a fresh matrix streams correctly.
5. **Ops between bursts:** check that `op_out`/`gauss_op_out` are 0 outside STREAM and equal the word-0-sampled values during it, even if `in_op` changes during LOAD.
6. **Single lane:** `N`=1, `ROWS`=2.
   - Lane 0 start and finish are one cycle apart.
   - `done` comes 2 cycles after the first output.
